// File: rtl/ddc_ctrl_pkg.sv
// Shared types and constants for the down-converter sequencer.
//   state_t  : sequencer states (idle, filter settling, running)
//   PH_W     : width of the fs/4 frame phase counter
//   PH_FSO4  : phase value that marks the frame boundary / fs/4 strobe
//   settle_w : width needed to hold a settle count of 0..settle
package ddc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int              PH_W    = 2;
  localparam logic [PH_W-1:0] PH_FSO4 = 2'd3;

  function automatic int settle_w(input int settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/ddc_phase_gen.sv
// Frame phase counter and stage-enable decode.
//   clk_fs, rstb : clock, async active-low reset
//   clr          : force phase to 0 (sequencer idle)
//   run          : advance phase each cycle (sequencer active)
//   phase        : current position within the 4-sample frame
//   en_fs        : sample-rate enable (every active cycle)
//   en_fso2      : fs/2 enable (odd phases)
//   en_fso4      : fs/4 enable (frame boundary)
module ddc_phase_gen
  import ddc_ctrl_pkg::*;
(
  input  logic            clk_fs,
  input  logic            rstb,
  input  logic            clr,
  input  logic            run,
  output logic [PH_W-1:0] phase,
  output logic            en_fs,
  output logic            en_fso2,
  output logic            en_fso4
);

  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb)    phase <= '0;
    else if (clr) phase <= '0;
    else if (run) phase <= phase + PH_W'(1);
  end

  // Decode from the registered phase only; gated by run so all enables
  // are low while the chain is parked.
  assign en_fs   = run;
  assign en_fso2 = run && phase[0];
  assign en_fso4 = run && (phase == PH_FSO4);

endmodule

// File: rtl/ddc_seq_ctrl.sv
// Sequencer for the mixer + two-stage FIR/decimate-by-2 down-converter.
//   clk_fs, rstb        : sampling clock, async active-low reset
//   start, stop         : begin operation / halt at next frame boundary
//   cfg_valid, cfg_wif  : retune request (valid/ready) and requested word
//   cfg_ready           : retune accepted this cycle when cfg_valid is high
//   wif                 : applied mixer tuning word
//   en_fs/en_fso2/en_fso4 : sample, fs/2 and fs/4 stage enables
//   flush               : one-cycle filter clear after start or retune
//   out_valid           : decimated I/Q output valid (post-settle strobes)
//   busy                : sequencer not idle
// Every output is a register or a decode of registers only.
module ddc_seq_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter int             ABW     = 10,
  parameter int             SETTLE  = 8,
  parameter logic [ABW-1:0] WIF_RST = '0
) (
  input  logic           clk_fs,
  input  logic           rstb,
  input  logic           start,
  input  logic           stop,
  input  logic           cfg_valid,
  input  logic [ABW-1:0] cfg_wif,
  output logic           cfg_ready,
  output logic [ABW-1:0] wif,
  output logic           en_fs,
  output logic           en_fso2,
  output logic           en_fso4,
  output logic           flush,
  output logic           out_valid,
  output logic           busy
);

  localparam int SCW = settle_w(SETTLE);

  state_t          state;
  logic            stop_pend;
  logic [SCW-1:0]  settle_cnt;
  logic [PH_W-1:0] phase;
  logic            idle;
  logic            boundary;
  logic            cfg_hs;

  assign idle     = (state == ST_IDLE);
  assign boundary = !idle && (phase == PH_FSO4);
  assign cfg_hs   = cfg_valid && cfg_ready;

  ddc_phase_gen u_phase (
    .clk_fs  (clk_fs),
    .rstb    (rstb),
    .clr     (idle),
    .run     (!idle),
    .phase   (phase),
    .en_fs   (en_fs),
    .en_fso2 (en_fso2),
    .en_fso4 (en_fso4)
  );

  // Retunes are only taken at a running frame boundary (or while idle),
  // and never once a stop is pending, so a retune cannot restart settling
  // on a chain that is about to halt.
  assign cfg_ready = !stop_pend && (idle || ((state == ST_RUN) && boundary));
  assign out_valid = en_fso4 && (state == ST_RUN);
  assign busy      = !idle;

  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      stop_pend  <= 1'b0;
      settle_cnt <= '0;
      flush      <= 1'b0;
      wif        <= WIF_RST;
    end else begin
      flush <= 1'b0;
      if (cfg_hs) wif <= cfg_wif;

      case (state)
        ST_IDLE: begin
          // start together with stop is treated as a cancelled start
          if (start && !stop) begin
            state      <= ST_SETTLE;
            settle_cnt <= SCW'(SETTLE);
            flush      <= 1'b1;
          end
        end

        ST_SETTLE, ST_RUN: begin
          if (boundary && (stop || stop_pend)) begin
            // Stop wins over a same-boundary retune: wif still updates
            // above, but no flush and no re-settle.
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
          end else begin
            if (stop) stop_pend <= 1'b1;
            if (boundary) begin
              if (state == ST_RUN) begin
                if (cfg_hs) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= SCW'(SETTLE);
                  flush      <= 1'b1;
                end
              end else if (settle_cnt == SCW'(1)) begin
                state <= ST_RUN;
              end else begin
                settle_cnt <= settle_cnt - SCW'(1);
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddc_seq_ctrl.sv
module tb_ddc_seq_ctrl;

  localparam int ABW    = 10;
  localparam int SETTLE = 8;
  localparam int RUNWIN = 4 * (SETTLE + 1);  // cycle of the first out_valid
  localparam int WINEND = RUNWIN + 4;

  logic           clk_fs = 1'b0;
  logic           rstb   = 1'b1;
  logic           start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
  logic [ABW-1:0] cfg_wif = '0;
  logic           cfg_ready, en_fs, en_fso2, en_fso4, flush, out_valid, busy;
  logic [ABW-1:0] wif;
  logic [5:0]     obs;

  int errs   = 0;
  int checks = 0;

  ddc_seq_ctrl #(.ABW(ABW), .SETTLE(SETTLE), .WIF_RST('0)) dut (
    .clk_fs    (clk_fs),
    .rstb      (rstb),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_wif   (cfg_wif),
    .cfg_ready (cfg_ready),
    .wif       (wif),
    .en_fs     (en_fs),
    .en_fso2   (en_fso2),
    .en_fso4   (en_fso4),
    .flush     (flush),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk_fs = ~clk_fs;

  assign obs = {busy, en_fs, en_fso2, en_fso4, flush, out_valid};

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_fs);
    #1;
  endtask

  // Cycle n=1 is the first cycle after start (or retune) is taken.
  // Expect fs/2 on even n, fs/4 on multiples of 4, flush at n=1, and
  // out_valid from strobe SETTLE+1 onward. Ends on a RUN frame boundary.
  task automatic run_window(input string tag);
    logic [5:0] exp;
    for (int n = 1; n <= WINEND; n++) begin
      exp = {1'b1, 1'b1, (n % 2 == 0), (n % 4 == 0), (n == 1),
             (n % 4 == 0) && (n >= RUNWIN)};
      checks++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL %s n=%0d got=%b want=%b", tag, n, obs, exp);
      end
      if (n < WINEND) tick();
    end
  endtask

  task automatic test_reset();
    #1 rstb = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin errs++; $display("FAIL reset_outs got=%b want=000000", obs); end
    checks++;
    if (cfg_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
    checks++;
    if (wif !== 10'h000) begin errs++; $display("FAIL reset_wif got=%h want=000", wif); end
    tick();
    rstb = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b0) begin errs++; $display("FAIL reset_idle got=%b want=000000", obs); end
  endtask

  task automatic test_idle_retune();
    cfg_valid = 1'b1; cfg_wif = 10'h155;
    checks++;
    if (cfg_ready !== 1'b1) begin errs++; $display("FAIL idle_ready got=%b want=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (wif !== 10'h155) begin errs++; $display("FAIL idle_wif got=%h want=155", wif); end
    checks++;
    if (obs !== 6'b0) begin errs++; $display("FAIL idle_retune_outs got=%b want=000000", obs); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_window("start_seq");
  endtask

  task automatic test_run_retune();
    tick();  // phase 0
    cfg_valid = 1'b1; cfg_wif = 10'h080;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (cfg_ready !== 1'b0 || wif !== 10'h155) begin
        errs++;
        $display("FAIL run_retune_hold p=%0d ready=%b wif=%h want ready=0 wif=155", p, cfg_ready, wif);
      end
      tick();
    end
    checks++;
    if (cfg_ready !== 1'b1) begin errs++; $display("FAIL run_retune_ready got=%b want=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (wif !== 10'h080) begin errs++; $display("FAIL run_retune_wif got=%h want=080", wif); end
    run_window("retune_seq");
  endtask

  task automatic test_stop();
    tick(); tick();  // phase 1
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL stop_pend ready=%b busy=%b want ready=0 busy=1", cfg_ready, busy);
    end
    tick();
    checks++;
    if (obs !== 6'b111101) begin errs++; $display("FAIL stop_last_strobe got=%b want=111101", obs); end
    tick();
    checks++;
    if (obs !== 6'b0 || cfg_ready !== 1'b1) begin
      errs++; $display("FAIL stop_idle got=%b ready=%b want=000000 ready=1", obs, cfg_ready);
    end
  endtask

  task automatic test_stop_retune_same();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_window("settle2_seq");
    checks++;
    if (cfg_ready !== 1'b1) begin errs++; $display("FAIL same_ready got=%b want=1", cfg_ready); end
    stop = 1'b1; cfg_valid = 1'b1; cfg_wif = 10'h2a5;
    tick();
    stop = 1'b0; cfg_valid = 1'b0;
    checks++;
    if (wif !== 10'h2a5) begin errs++; $display("FAIL same_wif got=%h want=2a5", wif); end
    checks++;
    if (obs !== 6'b0) begin errs++; $display("FAIL same_outs got=%b want=000000", obs); end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (obs !== 6'b0) begin errs++; $display("FAIL start_stop got=%b want=000000", obs); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL start_stop_busy got=%b want=0", busy); end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();  // mid-SETTLE
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0 || cfg_ready !== 1'b1 || wif !== 10'h000) begin
      errs++;
      $display("FAIL async_reset outs=%b ready=%b wif=%h want=000000 1 000", obs, cfg_ready, wif);
    end
    tick();
    rstb = 1'b1;
    tick();
    test_start();
  endtask

  // Reference model: the chain is either off or on; when on, the frame
  // phase is (cycles since start) mod 4 and outputs are valid once more
  // than SETTLE strobes have passed since the last start/retune.
  task automatic test_random();
    bit       on = 0, pend = 0, mflush = 0, bnd, runst, rdy, s, p, v, hs;
    int       age = 0, strobes = 0;
    logic [ABW-1:0] mwif = '0, w;
    logic [5:0] exp;
    #2 rstb = 1'b0;
    tick();
    rstb = 1'b1;
    tick();
    for (int c = 0; c < 2000; c++) begin
      bnd   = on && (age % 4 == 3);
      runst = (strobes >= SETTLE);
      rdy   = !pend && (!on || (bnd && runst));
      exp   = {on, on, on && (age % 2 == 1), bnd, mflush, bnd && runst};
      checks++;
      if (obs !== exp || cfg_ready !== rdy || wif !== mwif) begin
        errs++;
        $display("FAIL random c=%0d outs=%b ready=%b wif=%h want %b %b %h",
                 c, obs, cfg_ready, wif, exp, rdy, mwif);
      end
      s = ($urandom % 8 == 0);
      p = ($urandom % 40 == 0);
      v = ($urandom % 3 == 0);
      w = ABW'($urandom);
      start = s; stop = p; cfg_valid = v; cfg_wif = w;
      hs = v && rdy;
      if (hs) mwif = w;
      mflush = 0;
      if (!on) begin
        if (s && !p) begin on = 1; age = 0; strobes = 0; mflush = 1; end
      end else if (bnd && (p || pend)) begin
        on = 0; pend = 0; age = 0;
      end else begin
        if (p) pend = 1;
        if (bnd) begin
          if (hs) begin strobes = 0; mflush = 1; end
          else strobes++;
        end
        age++;
      end
      tick();
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_retune();
    test_start();
    test_run_retune();
    test_stop();
    test_stop_retune_same();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
